// File: rtl/traffic_phase_scheduler.sv
// Tick-timed two-road intersection phase sequencer with min/max green and all-red clearance.
// Optional pedestrian walk phase is enabled by defining PED_WALK_EN.
module traffic_phase_scheduler #(
    parameter int HW_MIN_GREEN  = 20,
    parameter int CNT_MIN_GREEN = 5,
    parameter int CNT_MAX_GREEN = 15,
    parameter int YELLOW_T      = 3,
    parameter int ALLRED_T      = 2,
    parameter int WALK_T        = 8,
    parameter int TW            = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       x,
    input  logic       ped_req,
    output logic [1:0] hi_way,
    output logic [1:0] cnt_way,
    output logic       walk,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        HG  = 3'd0,
        HY  = 3'd1,
        AR1 = 3'd2,
        CG  = 3'd3,
        CY  = 3'd4,
        AR2 = 3'd5,
        PW  = 3'd6,
        BAD = 3'd7
    } state_t;

    localparam logic [1:0] RED    = 2'd0;
    localparam logic [1:0] YELLOW = 2'd1;
    localparam logic [1:0] GREEN  = 2'd2;

    localparam logic [TW-1:0] HW_MIN   = TW'(HW_MIN_GREEN);
    localparam logic [TW-1:0] HW_M1    = TW'(HW_MIN_GREEN - 1);
    localparam logic [TW-1:0] CMIN     = TW'(CNT_MIN_GREEN);
    localparam logic [TW-1:0] CMIN_M1  = TW'(CNT_MIN_GREEN - 1);
    localparam logic [TW-1:0] CMAX_M1  = TW'(CNT_MAX_GREEN - 1);
    localparam logic [TW-1:0] YEL_M1   = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] AR_M1    = TW'(ALLRED_T - 1);
    localparam logic [TW-1:0] WALK_M1  = TW'(WALK_T - 1);
    localparam logic [TW-1:0] T_MAX    = {TW{1'b1}};

    state_t        state_reg, state_next;
    logic [TW-1:0] t_reg, t_next;
    logic          car_req_reg, car_req_next;
    logic          ped_pend;

    logic exp_yel, exp_ar, exp_cmin, exp_cmax, hw_reached, cg_done;

    assign exp_yel    = tick && (t_reg >= YEL_M1);
    assign exp_ar     = tick && (t_reg >= AR_M1);
    assign exp_cmin   = tick && (t_reg >= CMIN_M1);
    assign exp_cmax   = tick && (t_reg >= CMAX_M1);
    // Once the timer has run past min-green, a late request is served without waiting for a tick.
    assign hw_reached = (tick && (t_reg >= HW_M1)) || (t_reg >= HW_MIN);
    assign cg_done    = (!x && ((t_reg >= CMIN) || exp_cmin)) || exp_cmax;

`ifdef PED_WALK_EN
    logic ped_pend_reg, ped_pend_next;
    logic exp_walk;

    assign exp_walk = tick && (t_reg >= WALK_M1);
    assign ped_pend = ped_pend_reg;

    always_comb begin
        ped_pend_next = ped_pend_reg;
        if (state_next == PW && state_reg != PW)
            ped_pend_next = 1'b0;
        else if (ped_req)
            ped_pend_next = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ped_pend_reg <= 1'b0;
        else
            ped_pend_reg <= ped_pend_next;
    end
`else
    logic unused_ped;

    assign ped_pend   = 1'b0;
    assign unused_ped = ped_req | (&WALK_M1);
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            HG:  if (hw_reached && (car_req_reg || ped_pend)) state_next = HY;
            HY:  if (exp_yel) state_next = AR1;
            AR1: if (exp_ar) state_next = ped_pend ? PW : CG;
            CG:  if (cg_done) state_next = CY;
            CY:  if (exp_yel) state_next = AR2;
            AR2: if (exp_ar) state_next = HG;
`ifdef PED_WALK_EN
            PW:  if (exp_walk) state_next = car_req_reg ? CG : HG;
`endif
            default: state_next = HG;
        endcase
    end

    always_comb begin
        t_next = t_reg;
        if (state_next != state_reg)
            t_next = '0;
        else if (tick && (t_reg != T_MAX))
            t_next = t_reg + 1'b1;
    end

    // Entering CG consumes the request; x seen while green is already being served.
    always_comb begin
        car_req_next = car_req_reg;
        if (state_next == CG && state_reg != CG)
            car_req_next = 1'b0;
        else if (x && state_reg != CG)
            car_req_next = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= HG;
            t_reg       <= '0;
            car_req_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            t_reg       <= t_next;
            car_req_reg <= car_req_next;
        end
    end

    always_comb begin
        hi_way  = RED;
        cnt_way = RED;
        walk    = 1'b0;
        case (state_reg)
            HG:      hi_way  = GREEN;
            HY:      hi_way  = YELLOW;
            CG:      cnt_way = GREEN;
            CY:      cnt_way = YELLOW;
`ifdef PED_WALK_EN
            PW:      walk    = 1'b1;
`endif
            default: ;
        endcase
    end

    assign phase = state_reg;

endmodule

// File: doc/traffic_phase_scheduler.md
# traffic_phase_scheduler

Timer-driven phase sequencer for the two-road (highway / country-road) intersection. It replaces fixed clock-count delays with parameterised, tick-scaled phase timers, latches sensor requests, and enforces minimum and maximum green and all-red clearance. It drives the `hi_way` / `cnt_way` lamp codes directly and sits between the sensor front-end and the lamp drivers.

## Interface
- `HW_MIN_GREEN`, 20: minimum highway green, in ticks (≥1).
- `CNT_MIN_GREEN`, 5: minimum country-road green, in ticks (≥1).
- `CNT_MAX_GREEN`, 15: maximum country-road green, in ticks (≥ `CNT_MIN_GREEN`).
- `YELLOW_T`, 3: yellow duration, in ticks (≥1).
- `ALLRED_T`, 2: all-red clearance, in ticks (≥1).
- `WALK_T`, 8: pedestrian walk duration, in ticks (≥1); used only with `PED_WALK_EN`.
- `TW`, 8: phase timer width; every duration must be < 2^TW.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `tick`  in  1  timebase enable, one `clk` wide (e.g. 1 Hz strobe).
- `x`  in  1  country-road car sensor, level.
- `ped_req`  in  1  pedestrian button, level or pulse; used only with `PED_WALK_EN`.
- `hi_way`  out  2  highway lamp code: RED=0, YELLOW=1, GREEN=2.
- `cnt_way`  out  2  country-road lamp code, same encoding.
- `walk`  out  1  pedestrian walk lamp; tied 0 without `PED_WALK_EN`.
- `phase`  out  3  current state encoding, for status and debug.

## Operation
- States and `phase` codes:
  - HG=0: `hi_way` GREEN, `cnt_way` RED.
  - HY=1: `hi_way` YELLOW, `cnt_way` RED.
  - AR1=2: both RED.
  - CG=3: `hi_way` RED, `cnt_way` GREEN.
  - CY=4: `hi_way` RED, `cnt_way` YELLOW.
  - AR2=5: both RED.
  - PW=6: both RED, `walk`=1.
- Lamp outputs and `walk` are a pure decode of the state register. Unused code 7 decodes as AR1 lamps and transitions to HG on the next edge.
- Phase timer `t`:
  - Cleared to 0 on every state change.
  - Otherwise increments on `tick`, saturating at 2^TW−1.
  - `exp(N)` = `tick` && (`t` ≥ N−1).
- `car_req` latch:
  - Set on any edge where `x`=1 and state ≠ CG.
  - Cleared on entry to CG; entry has priority over set.
- `ped_pend` latch (macro only):
  - Set on any edge where `ped_req`=1.
  - Cleared on entry to PW; entry has priority over set.
- Transitions, evaluated each edge:
  - HG → HY when `exp(HW_MIN_GREEN)`-reached and (`car_req` or `ped_pend`). "Reached" means `t` ≥ `HW_MIN_GREEN`−1 with `tick`, or `t` ≥ `HW_MIN_GREEN` (no tick needed once saturated past).
  - HY → AR1 on `exp(YELLOW_T)`.
  - AR1 → PW on `exp(ALLRED_T)` when `ped_pend`; otherwise AR1 → CG on `exp(ALLRED_T)`.
  - PW → CG on `exp(WALK_T)` when `car_req`; otherwise PW → HG on `exp(WALK_T)`.
  - CG → CY when (`t` ≥ `CNT_MIN_GREEN` and `x`=0), or `exp(CNT_MIN_GREEN)` with `x`=0, or `exp(CNT_MAX_GREEN)`.
  - CY → AR2 on `exp(YELLOW_T)`.
  - AR2 → HG on `exp(ALLRED_T)`.
- With no request pending, HG is held indefinitely.

## Timing
- Reset (async assert):
  - State HG, `t`=0, both latches 0.
  - `hi_way`=2, `cnt_way`=0, `walk`=0, `phase`=0, all immediately.
  - Reset deassertion is synchronised by the integrator; the first active edge after release may advance `t`.
- With `tick` tied high, a timed phase of duration N lasts exactly N cycles.
- With no `tick`, no phase ever expires; requests still latch.
- HG minimum is measured from HG entry, not from request arrival. A request arriving after min-green is served on the next edge.
- `x` dropping in CG before min-green does not shorten the green.
- Holding `x` in CG ends the green at `CNT_MAX_GREEN`. Because `x` is still high in CY, `car_req` re-latches, and the controller cycles back after `HW_MIN_GREEN`.
- Outputs change on the same edge as `phase`; there is no extra latency.

## Configuration
- `PED_WALK_EN` defined:
  - PW state, `ped_pend`, and the `ped_req` / `walk` behaviour are present.
  - A pending pedestrian request alone can end HG.
- `PED_WALK_EN` undefined:
  - PW is unreachable and not synthesised; `ped_pend` is constant 0.
  - `ped_req` is ignored and `walk` is tied 0.
  - AR1 → CG unconditionally on expiry.

## Test plan
- Reset, `tick`=1, `x`=0 for 100 cycles → `phase`=0, `hi_way`=2, `cnt_way`=0 throughout.
- Reset, `tick`=1, `x`=1 held → HG 20, HY 3, AR1 2, CG 15, CY 3, AR2 2 cycles, then HG for 20 cycles before HY again.
- `x` pulsed 1 cycle at cycle 2, `tick`=1 → HY at cycle 20. CG lasts exactly 5 cycles. After AR2, HG holds indefinitely.
- `tick` every 4th cycle, `x`=1 → HY lasts 12 cycles. With `tick` held 0 mid-CG, `phase` freezes at 3.
- `reset_n` pulsed low mid-CG → `hi_way`=2, `cnt_way`=0, `phase`=0 asynchronously, before the next edge. Latches read 0.
- `PED_WALK_EN`, `ped_req` pulse, `x`=0 → HG 20, HY 3, AR1 2, then PW 8 cycles with `walk`=1, then HG. With `x`=1 also set, PW → CG.
